// File: rtl/stim_pattern_gen.sv
// rtl/stim_pattern_gen.sv - exhaustive binary/Gray/LFSR stimulus sweep with programmable per-vector hold
// LFSR mode and its tap table are built only when STIM_LFSR_EN is defined.
module stim_pattern_gen #(
    parameter int WIDTH  = 4,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [HOLD_W-1:0] period,
    output logic [WIDTH-1:0]  vec,
    output logic              vec_valid,
    output logic [WIDTH-1:0]  vec_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0]       MODE_GRAY = 2'b01;
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef STIM_LFSR_EN
    localparam logic [1:0] MODE_LFSR = 2'b10;

    function automatic logic [WIDTH-1:0] tap_mask();
        logic [7:0] m;
        case (WIDTH)
            2:       m = 8'h03;
            3:       m = 8'h06;
            4:       m = 8'h0C;
            5:       m = 8'h14;
            6:       m = 8'h30;
            7:       m = 8'h60;
            default: m = 8'hB8;
        endcase
        return m[WIDTH-1:0];
    endfunction

    localparam logic [WIDTH-1:0] TAPS = tap_mask();
`endif

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    vec_q, vec_d;
    logic [WIDTH-1:0]    idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [HOLD_W-1:0]   period_q, period_d;
    logic [1:0]          mode_q, mode_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                run_lfsr;
    logic                start_lfsr;
    logic                run_gray;
    logic [WIDTH-1:0]    last_idx;
    logic [WIDTH-1:0]    idx_next;
    logic [WIDTH-1:0]    code_next;

    // Sweep code decode: reserved mode 11 (and 10 without LFSR support) falls back to binary.
    always_comb begin
        run_gray = (mode_q == MODE_GRAY);
`ifdef STIM_LFSR_EN
        run_lfsr   = (mode_q == MODE_LFSR);
        start_lfsr = (mode == MODE_LFSR);
`else
        run_lfsr   = 1'b0;
        start_lfsr = 1'b0;
`endif
        // LFSR never visits zero, so its sweep is one vector shorter.
        last_idx = run_lfsr ? (ALL_ONES - ONE) : ALL_ONES;
        idx_next = idx_q + ONE;
        if (run_lfsr) begin
`ifdef STIM_LFSR_EN
            code_next = {vec_q[WIDTH-2:0], ^(vec_q & TAPS)};
`else
            code_next = idx_next;
`endif
        end else if (run_gray) begin
            code_next = idx_next ^ (idx_next >> 1);
        end else begin
            code_next = idx_next;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        period_d = period_q;
        mode_d   = mode_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start && !stop) begin
                    state_d  = S_RUN;
                    mode_d   = mode;
                    period_d = period;
                    hold_d   = period;
                    idx_d    = '0;
                    vec_d    = start_lfsr ? ONE : '0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (hold_q == '0) begin
                    if (idx_q == last_idx) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_next;
                        vec_d   = code_next;
                        hold_d  = period_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            idx_q    <= '0;
            hold_q   <= '0;
            period_q <= '0;
            mode_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign vec       = vec_q;
    assign vec_idx   = idx_q;
    assign vec_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_stim_pattern_gen.sv
// tb/tb_stim_pattern_gen.sv - directed self-checking bench for stim_pattern_gen (WIDTH=4, HOLD_W=8)
module tb_stim_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [7:0] period;
    logic [3:0] vec;
    logic       vec_valid;
    logic [3:0] vec_idx;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    int lfsr_tab [16] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 0};

    stim_pattern_gen #(.WIDTH(4), .HOLD_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .period    (period),
        .vec       (vec),
        .vec_valid (vec_valid),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vcount;
        int len;
        int exp_v;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00; period = 8'd0;
        step(); step();
        chk("rst_vec", 32'(vec), 0);
        chk("rst_idx", 32'(vec_idx), 0);
        chk("rst_valid", 32'(vec_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 0);

        // binary, period 0
        mode = 2'b00; period = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("bin_vec", 32'(vec), 32'(i));
            chk("bin_idx", 32'(vec_idx), 32'(i));
            chk("bin_valid", 32'(vec_valid), 1);
            chk("bin_busy", 32'(busy), 1);
            chk("bin_done_low", 32'(done), 0);
            step();
        end
        chk("bin_end_busy", 32'(busy), 0);
        chk("bin_end_done", 32'(done), 1);
        chk("bin_end_vec", 32'(vec), 15);
        chk("bin_end_valid", 32'(vec_valid), 0);
        step();
        chk("bin_done_pulse", 32'(done), 0);
        chk("bin_hold_vec", 32'(vec), 15);

        // Gray, period 2, with ignored start/mode/period changes mid-sweep
        mode = 2'b01; period = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        vcount = 0;
        for (int c = 0; c < 48; c++) begin
            chk("gray_vec", 32'(vec), 32'(gray_tab[c / 3]));
            chk("gray_valid", 32'(vec_valid), ((c % 3) == 0) ? 1 : 0);
            chk("gray_busy", 32'(busy), 1);
            if (vec_valid) vcount++;
            if (c == 10) begin
                start = 1'b1; mode = 2'b00; period = 8'd5;
            end
            if (c == 11) start = 1'b0;
            step();
        end
        chk("gray_valid_count", 32'(vcount), 16);
        chk("gray_end_busy", 32'(busy), 0);
        chk("gray_end_done", 32'(done), 1);
        chk("gray_end_vec", 32'(vec), 8);
        step();

        // LFSR (binary when the option is not built)
        mode = 2'b10; period = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
`ifdef STIM_LFSR_EN
        len = 15;
`else
        len = 16;
`endif
        for (int i = 0; i < len; i++) begin
            exp_v = (len == 15) ? lfsr_tab[i] : i;
            chk("lfsr_vec", 32'(vec), 32'(exp_v));
            chk("lfsr_idx", 32'(vec_idx), 32'(i));
            chk("lfsr_busy", 32'(busy), 1);
            step();
        end
        chk("lfsr_end_done", 32'(done), 1);
        chk("lfsr_end_busy", 32'(busy), 0);
        chk("lfsr_end_vec", 32'(vec), (len == 15) ? 8 : 15);
        step();

        // stop during binary, period 3
        mode = 2'b00; period = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (vec == 4'd5) break;
            step();
        end
        chk("stop_reach_vec5", 32'(vec), 5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_vec", 32'(vec), 5);
        chk("stop_idx", 32'(vec_idx), 5);
        chk("stop_done", 32'(done), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stop_idle_done", 32'(done), 0);
            chk("stop_idle_busy", 32'(busy), 0);
            chk("stop_idle_vec", 32'(vec), 5);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_vec", 32'(vec), 0);
        chk("restart_idx", 32'(vec_idx), 0);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_valid", 32'(vec_valid), 1);

        // asynchronous reset mid-sweep
        for (int k = 0; k < 200; k++) begin
            if (vec == 4'd9) break;
            step();
        end
        chk("rst_reach_vec9", 32'(vec), 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vec", 32'(vec), 0);
        chk("arst_idx", 32'(vec_idx), 0);
        chk("arst_valid", 32'(vec_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        step();
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_done", 32'(done), 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 32'(busy), 0);
        chk("startstop_valid", 32'(vec_valid), 0);
        step();
        chk("startstop_busy2", 32'(busy), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("final_start_busy", 32'(busy), 1);
        chk("final_start_valid", 32'(vec_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
